// File: rtl/scale_pkg.sv
// ---------------------------------------------------------------------------
// scale_pkg
// Shared definitions for the scale weight divider slice: the divider FSM
// state encoding and the default width/divisor used by the scale datapath.
// Imported by scale_div_step and scale_weight_divider.
// ---------------------------------------------------------------------------
package scale_pkg;

  // Divider control states: waiting for a weight, running the restoring
  // iterations, and presenting a result until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } scale_state_e;

  // Grams per kilogram, the divisor the display stage expects by default.
  localparam int SCALE_DEFAULT_DIVISOR = 1000;

  // Enough bits for the load-cell range in grams.
  localparam int SCALE_DEFAULT_W = 14;

endpackage

// File: rtl/scale_div_step.sv
// ---------------------------------------------------------------------------
// scale_div_step
// One combinational restoring-division step. The running remainder is
// shifted left by one, the next dividend bit is appended, and DIVISOR is
// subtracted when that is possible without going negative.
//
// Parameters:
//   DIVISOR  constant divisor
//   RW       remainder width; the running remainder is RW+1 bits
// Ports:
//   rem_i    running remainder before this step (always < DIVISOR)
//   bit_i    next dividend bit, taken MSB first
//   rem_o    running remainder after this step (always < DIVISOR)
//   qbit_o   quotient bit produced by this step
// ---------------------------------------------------------------------------
module scale_div_step
  import scale_pkg::*;
#(
  parameter int DIVISOR = SCALE_DEFAULT_DIVISOR,
  parameter int RW      = $clog2(DIVISOR)
) (
  input  logic [RW:0] rem_i,
  input  logic        bit_i,
  output logic [RW:0] rem_o,
  output logic        qbit_o
);

  localparam logic [RW+1:0] DIV_EXT = (RW + 2)'(DIVISOR);

  logic [RW+1:0] trial;
  logic [RW+1:0] diff;
  logic          unusedCarry;

  // The trial value is one bit wider than the remainder register so the
  // shift can never lose a bit; since rem_i < DIVISOR the trial stays below
  // 2*DIVISOR and its top bit is always zero, which is why only the low
  // RW+1 bits are carried forward.
  always_comb begin
    trial = {rem_i, bit_i};
    diff  = trial - DIV_EXT;
    if (trial >= DIV_EXT) begin
      rem_o  = diff[RW:0];
      qbit_o = 1'b1;
    end else begin
      rem_o  = trial[RW:0];
      qbit_o = 1'b0;
    end
  end

  assign unusedCarry = trial[RW+1] ^ diff[RW+1];

endmodule

// File: rtl/scale_weight_divider.sv
// ---------------------------------------------------------------------------
// scale_weight_divider
// Sequential gram-to-kilogram converter. A weight accepted over a
// valid/ready handshake is divided by DIVISOR with an iterative restoring
// divider, one quotient bit per clock, MSB first. The quotient (whole
// kilograms) and remainder (grams) are registered and held until the
// consumer takes them.
//
// Optional feature, enabled by defining the macro SCALE_TARE_EN:
//   a tare register captured by tare_set_i is subtracted from the weight at
//   acceptance; a negative net weight is clamped to 0 and flagged on
//   under_tare_o. Without the macro, tare_set_i is ignored and under_tare_o
//   is constant 0. The port list is the same in both builds.
//
// Parameters:
//   W        width of the weight input and of the quotient output
//   DIVISOR  constant divisor, 2 <= DIVISOR < 2**W
//   RW       remainder width, derived from DIVISOR; do not override
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     weight_in_i is valid
//   in_ready_o     block can accept a weight (high only in IDLE)
//   weight_in_i    weight in grams, unsigned
//   tare_set_i     one-cycle pulse capturing weight_in_i as the tare value
//   out_valid_o    result is valid
//   out_ready_i    consumer takes the result
//   weight_int_o   quotient, whole kilograms
//   weight_frac_o  remainder, grams in 0..DIVISOR-1
//   under_tare_o   net weight was negative and was clamped to 0
// ---------------------------------------------------------------------------
module scale_weight_divider
  import scale_pkg::*;
#(
  parameter int W       = SCALE_DEFAULT_W,
  parameter int DIVISOR = SCALE_DEFAULT_DIVISOR,
  parameter int RW      = $clog2(DIVISOR)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  weight_in_i,
  input  logic          tare_set_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  weight_int_o,
  output logic [RW-1:0] weight_frac_o,
  output logic          under_tare_o
);

  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  scale_state_e  state_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  dividend_q;
  logic [W-1:0]  quotient_q;
  logic [RW:0]   remainder_q;
  logic [CW-1:0] bitCount_q;
  logic [W-1:0]  weight_int_q;
  logic [RW-1:0] weight_frac_q;

  logic [W-1:0]  dividend_d;
  logic [W-1:0]  quotient_d;
  logic [RW:0]   remainder_d;
  logic          stepBit;

  // The restoring step itself lives in its own module; the top only feeds
  // it the running remainder and the current MSB of the shifting dividend.
  scale_div_step #(
    .DIVISOR (DIVISOR),
    .RW      (RW)
  ) u_step (
    .rem_i  (remainder_q),
    .bit_i  (dividend_q[W-1]),
    .rem_o  (remainder_d),
    .qbit_o (stepBit)
  );

  assign quotient_d = {quotient_q[W-2:0], stepBit};

`ifdef SCALE_TARE_EN
  logic [W-1:0] tare_q;
  logic         underPending_q;
  logic         under_tare_q;
  logic         underFlag_d;

  // Net weight at acceptance. The tare register is read before any update
  // on the same edge, so a tare_set coinciding with acceptance still uses
  // the old tare. A negative net is clamped to zero and flagged.
  always_comb begin
    if (weight_in_i >= tare_q) begin
      dividend_d  = weight_in_i - tare_q;
      underFlag_d = 1'b0;
    end else begin
      dividend_d  = '0;
      underFlag_d = 1'b1;
    end
  end

  // The tare register may be loaded in any state; a conversion already in
  // flight has its net dividend latched, so it is unaffected.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tare_q <= '0;
    end else if (tare_set_i) begin
      tare_q <= weight_in_i;
    end
  end

  assign under_tare_o = under_tare_q;
`else
  logic unusedTareSet;

  assign dividend_d    = weight_in_i;
  assign under_tare_o  = 1'b0;
  assign unusedTareSet = tare_set_i;
`endif

  // Main control FSM with all handshake and result outputs registered.
  // IDLE latches the dividend and starts the counter at the MSB index; DIV
  // runs one restoring step per clock and, on the step with counter zero,
  // registers the final quotient and remainder directly from the step
  // outputs so the result appears W clocks after acceptance; DONE holds the
  // result until out_ready_i. in_ready is only re-raised when leaving DONE,
  // so there is no combinational path from out_ready_i to in_ready_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      dividend_q     <= '0;
      quotient_q     <= '0;
      remainder_q    <= '0;
      bitCount_q     <= '0;
      weight_int_q   <= '0;
      weight_frac_q  <= '0;
`ifdef SCALE_TARE_EN
      underPending_q <= 1'b0;
      under_tare_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_q) begin
            dividend_q     <= dividend_d;
            quotient_q     <= '0;
            remainder_q    <= '0;
            bitCount_q     <= LAST_BIT;
            in_ready_q     <= 1'b0;
`ifdef SCALE_TARE_EN
            underPending_q <= underFlag_d;
`endif
            state_q        <= DIV;
          end
        end

        DIV: begin
          dividend_q  <= dividend_q << 1;
          quotient_q  <= quotient_d;
          remainder_q <= remainder_d;
          bitCount_q  <= bitCount_q - CW'(1);
          if (bitCount_q == '0) begin
            weight_int_q  <= quotient_d;
            weight_frac_q <= remainder_d[RW-1:0];
`ifdef SCALE_TARE_EN
            under_tare_q  <= underPending_q;
`endif
            out_valid_q   <= 1'b1;
            state_q       <= DONE;
          end
        end

        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign weight_int_o  = weight_int_q;
  assign weight_frac_o = weight_frac_q;

endmodule

// File: tb/tb_scale_weight_divider.sv
// ---------------------------------------------------------------------------
// tb_scale_weight_divider
// Directed bench for scale_weight_divider: reset values, plain conversions
// with latency, backpressure, tare behaviour (both builds), reset during a
// conversion, a random sweep against / and %, and two other parameter sets.
// ---------------------------------------------------------------------------
module tb_scale_weight_divider;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [13:0] weightIn;
  logic        tareSet;
  logic        outValid;
  logic        outReady;
  logic [13:0] weightInt;
  logic [9:0]  weightFrac;
  logic        underTare;

  logic        inValid8, inReady8, outValid8, outReady8, underTare8, tareSet8;
  logic [7:0]  weightIn8, weightInt8;
  logic [3:0]  weightFrac8;

  logic        inValid16, inReady16, outValid16, outReady16, underTare16, tareSet16;
  logic [15:0] weightIn16, weightInt16;
  logic [9:0]  weightFrac16;

  int checkCount = 0;
  int passCount  = 0;

  scale_weight_divider dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .in_valid_i    (inValid),
    .in_ready_o    (inReady),
    .weight_in_i   (weightIn),
    .tare_set_i    (tareSet),
    .out_valid_o   (outValid),
    .out_ready_i   (outReady),
    .weight_int_o  (weightInt),
    .weight_frac_o (weightFrac),
    .under_tare_o  (underTare)
  );

  scale_weight_divider #(.W(8), .DIVISOR(10)) dut8 (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .in_valid_i    (inValid8),
    .in_ready_o    (inReady8),
    .weight_in_i   (weightIn8),
    .tare_set_i    (tareSet8),
    .out_valid_o   (outValid8),
    .out_ready_i   (outReady8),
    .weight_int_o  (weightInt8),
    .weight_frac_o (weightFrac8),
    .under_tare_o  (underTare8)
  );

  scale_weight_divider #(.W(16), .DIVISOR(1000)) dut16 (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .in_valid_i    (inValid16),
    .in_ready_o    (inReady16),
    .weight_in_i   (weightIn16),
    .tare_set_i    (tareSet16),
    .out_valid_o   (outValid16),
    .out_ready_i   (outReady16),
    .weight_int_o  (weightInt16),
    .weight_frac_o (weightFrac16),
    .under_tare_o  (underTare16)
  );

  // Free-running 10 ns clock; inputs change and outputs are sampled on the
  // falling edge, away from the active edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Presents one weight for exactly one accepting edge; entered and left
  // just after a falling edge with the DUT idle.
  task automatic applyStimulus(input logic [13:0] w);
    inValid  = 1'b1;
    weightIn = w;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  // Counts rising edges after acceptance until out_valid is seen, with an
  // optional tare pulse on the third DIV cycle. Bounded at 40 cycles.
  task automatic waitResult(output int lat, input bit pulseTare,
                            input logic [13:0] tareVal);
    lat = 0;
    while (!outValid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      tareSet = pulseTare && (lat == 3);
      if (tareSet) weightIn = tareVal;
    end
    tareSet = 1'b0;
  endtask

  // Takes the result with a one-cycle out_ready pulse and checks the block
  // is ready again on the following cycle.
  task automatic handshake(input string tag);
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
    checkOutput({tag, ".validDrop"}, outValid, 0);
    checkOutput({tag, ".readyBack"}, inReady, 1);
  endtask

  task automatic convertAndCheck(input string tag, input logic [13:0] w,
                                 input int expInt, input int expFrac,
                                 input bit expUnder, input bit pulseTare,
                                 input logic [13:0] tareVal);
    int lat;
    applyStimulus(w);
    checkOutput({tag, ".busy"}, inReady, 0);
    waitResult(lat, pulseTare, tareVal);
    checkOutput({tag, ".latency"}, lat, 14);
    checkOutput({tag, ".int"}, weightInt, expInt);
    checkOutput({tag, ".frac"}, weightFrac, expFrac);
    checkOutput({tag, ".under"}, underTare, expUnder);
    handshake(tag);
  endtask

  task automatic pulseTareSet(input logic [13:0] val);
    tareSet  = 1'b1;
    weightIn = val;
    @(posedge clk);
    @(negedge clk);
    tareSet = 1'b0;
  endtask

  initial begin
    int lat;
    int sent;
    int received;
    logic [13:0] w;

    rstN = 1'b0; inValid = 1'b0; weightIn = '0; tareSet = 1'b0; outReady = 1'b0;
    inValid8 = 1'b0; weightIn8 = '0; tareSet8 = 1'b0; outReady8 = 1'b1;
    inValid16 = 1'b0; weightIn16 = '0; tareSet16 = 1'b0; outReady16 = 1'b1;
    repeat (2) @(negedge clk);

    checkOutput("reset.inReady", inReady, 1);
    checkOutput("reset.outValid", outValid, 0);
    checkOutput("reset.int", weightInt, 0);
    checkOutput("reset.frac", weightFrac, 0);
    checkOutput("reset.under", underTare, 0);
    rstN = 1'b1;
    @(negedge clk);

    convertAndCheck("c1500", 14'd1500, 1, 500, 0, 0, '0);
    convertAndCheck("c0", 14'd0, 0, 0, 0, 0, '0);
    convertAndCheck("c999", 14'd999, 0, 999, 0, 0, '0);
    convertAndCheck("c16383", 14'd16383, 16, 383, 0, 0, '0);
    convertAndCheck("c1000", 14'd1000, 1, 0, 0, 0, '0);

    // Backpressure: result must hold and a new request must be refused.
    applyStimulus(14'd1500);
    waitResult(lat, 0, '0);
    checkOutput("bp.latency", lat, 14);
    for (int i = 0; i < 5; i++) begin
      inValid  = 1'b1;
      weightIn = 14'd777;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp.holdValid", outValid, 1);
      checkOutput("bp.holdInt", weightInt, 1);
      checkOutput("bp.holdFrac", weightFrac, 500);
      checkOutput("bp.notReady", inReady, 0);
    end
    inValid = 1'b0;
    handshake("bp");
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp.noSpuriousAccept", inReady, 1);

`ifdef SCALE_TARE_EN
    pulseTareSet(14'd200);
    convertAndCheck("tare200", 14'd1500, 1, 300, 0, 0, '0);
    pulseTareSet(14'd2000);
    convertAndCheck("tare2000", 14'd1500, 0, 0, 1, 0, '0);
    pulseTareSet(14'd200);
    convertAndCheck("tareMidDiv", 14'd1500, 1, 300, 0, 1, 14'd2000);
    convertAndCheck("tareAfterMid", 14'd1500, 0, 0, 1, 0, '0);
`else
    pulseTareSet(14'd200);
    convertAndCheck("tareIgnored", 14'd1500, 1, 500, 0, 1, 14'd2000);
`endif

    // Reset on the seventh DIV cycle aborts the conversion.
    applyStimulus(14'd1500);
    repeat (7) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("rstMid.inReady", inReady, 1);
    checkOutput("rstMid.outValid", outValid, 0);
    checkOutput("rstMid.int", weightInt, 0);
    checkOutput("rstMid.frac", weightFrac, 0);
    checkOutput("rstMid.under", underTare, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    convertAndCheck("afterRst", 14'd1500, 1, 500, 0, 0, '0);

    // Random sweep with random consumer stalls; tare is zero after reset.
    sent = 0;
    received = 0;
    for (int n = 0; n < 300; n++) begin
      w = 14'($urandom_range(0, 16383));
      applyStimulus(w);
      sent++;
      waitResult(lat, 0, '0);
      if (outValid) received++;
      checkOutput("rnd.int", weightInt, w / 1000);
      checkOutput("rnd.frac", weightFrac, w % 1000);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("rnd.stallHold", {weightInt, weightFrac, outValid},
                    {w / 14'd1000, 10'(w % 14'd1000), 1'b1});
      end
      outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      outReady = 1'b0;
      checkOutput("rnd.noDup", outValid, 0);
    end
    checkOutput("rnd.resultCount", received, sent);

    // W=8, DIVISOR=10: 255 -> 25 rem 5 after 8 cycles.
    inValid8  = 1'b1;
    weightIn8 = 8'd255;
    @(posedge clk);
    @(negedge clk);
    inValid8 = 1'b0;
    lat = 0;
    while (!outValid8 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput("w8.latency", lat, 8);
    checkOutput("w8.int", weightInt8, 25);
    checkOutput("w8.frac", weightFrac8, 5);
    @(negedge clk);
    checkOutput("w8.readyBack", inReady8, 1);

    // W=16, DIVISOR=1000: 65535 -> 65 rem 535 after 16 cycles.
    inValid16  = 1'b1;
    weightIn16 = 16'd65535;
    @(posedge clk);
    @(negedge clk);
    inValid16 = 1'b0;
    lat = 0;
    while (!outValid16 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput("w16.latency", lat, 16);
    checkOutput("w16.int", weightInt16, 65);
    checkOutput("w16.frac", weightFrac16, 535);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
